// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit header layout, register map and transmit FSM states.
// The receive interface uses the same map and header positions.
package noc_pkg;

   localparam int HDR_DEST_MSB = 31;
   localparam int HDR_DEST_LSB = 24;
   localparam int HDR_SRC_MSB  = 23;
   localparam int HDR_SRC_LSB  = 16;
   localparam int HDR_LEN_MSB  = 15;
   localparam int HDR_LEN_LSB  = 8;

   localparam logic [1:0] No_Transfer = 2'b00;

   localparam logic [4:0] ADDR_BYTE_LEN = 5'd8;
   localparam logic [4:0] ADDR_DEST     = 5'd9;
   localparam logic [4:0] ADDR_CONTROL  = 5'd10;
   localparam logic [4:0] ADDR_STATUS   = 5'd16;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_ACK = 2'd1,
      SEND     = 2'd2
   } tx_state_t;

endpackage

// File: rtl/ahb_tx.sv
// AHB-Lite slave transmit interface: buffers a payload written by the processor and
// sends it to the network as one header flit followed by back-to-back payload flits.
module ahb_tx
   import noc_pkg::*;
#(
   parameter int MAX_WORDS = 8
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic [31:0] HADDR,
   input  logic [31:0] HWDATA,
   input  logic [2:0]  HSIZE,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic        HREADY,
   input  logic        HSEL,
   output logic [31:0] HRDATA,
   output logic        HREADYOUT,
   input  logic [3:0]  My_Addr,
   output logic        M_Req,
   input  logic        M_Ack,
   output logic [31:0] M_Data
);

   localparam int PTR_W = $clog2(MAX_WORDS);

   tx_state_t        state;
   logic             write_en;
   logic             read_en;
   logic [4:0]       word_addr;
   logic [31:0]      tx_data [MAX_WORDS];
   logic [5:0]       byte_len;
   logic [3:0]       dest_addr;
   logic [3:0]       words;
   logic [PTR_W-1:0] ptr;
   logic             err;
   logic             sent;

   logic             busy;
   logic             in_buf;
   logic             send_req;
   logic             len_bad;
   logic [6:0]       len_round;
   logic             last_word;
   logic [31:0]      header;
   logic             unused_bits;

   assign HREADYOUT   = 1'b1;
   assign unused_bits = ^{HSIZE, HADDR[31:7], HADDR[1:0]};

   assign busy      = (state != IDLE);
   assign in_buf    = (word_addr < 5'(MAX_WORDS));
   assign send_req  = write_en && (word_addr == ADDR_CONTROL) && HWDATA[0];
   assign len_bad   = (byte_len == 6'd0) || (byte_len > 6'(4 * MAX_WORDS));
   assign len_round = {1'b0, byte_len} + 7'd3;
   assign last_word = (4'(ptr) == words - 4'd1);

   always_comb begin
      header = '0;
      header[HDR_DEST_MSB:HDR_DEST_LSB] = {4'd0, dest_addr};
      header[HDR_SRC_MSB:HDR_SRC_LSB]   = {4'd0, My_Addr};
      header[HDR_LEN_MSB:HDR_LEN_LSB]   = {2'd0, words, 2'd0};
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state     <= IDLE;
         write_en  <= 1'b0;
         read_en   <= 1'b0;
         word_addr <= '0;
         tx_data   <= '{default: '0};
         byte_len  <= '0;
         dest_addr <= '0;
         words     <= '0;
         ptr       <= '0;
         err       <= 1'b0;
         sent      <= 1'b0;
      end else begin
         // address phase -> data phase
         if (HREADY && HSEL && (HTRANS != No_Transfer)) begin
            write_en  <= HWRITE;
            read_en   <= !HWRITE;
            word_addr <= HADDR[6:2];
         end else begin
            write_en <= 1'b0;
            read_en  <= 1'b0;
         end

         // payload and packet parameters are frozen while a packet is in flight
         if (write_en && !busy) begin
            if (in_buf)
               tx_data[word_addr[PTR_W-1:0]] <= HWDATA;
            else if (word_addr == ADDR_BYTE_LEN)
               byte_len <= HWDATA[5:0];
            else if (word_addr == ADDR_DEST)
               dest_addr <= HWDATA[3:0];
         end

         case (state)
            IDLE: begin
               if (send_req) begin
                  if (len_bad) begin
                     err <= 1'b1;
                  end else begin
                     err   <= 1'b0;
                     sent  <= 1'b0;
                     words <= len_round[5:2];
                     state <= WAIT_ACK;
                  end
               end
            end
            WAIT_ACK: begin
               if (M_Ack) begin
                  ptr   <= '0;
                  state <= SEND;
               end
            end
            SEND: begin
               if (last_word) begin
                  sent  <= 1'b1;
                  state <= IDLE;
               end else begin
                  ptr <= ptr + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      M_Req  = 1'b0;
      M_Data = '0;
      case (state)
         WAIT_ACK: begin
            M_Req  = 1'b1;
            M_Data = header;
         end
         SEND:    M_Data = tx_data[ptr];
         default: M_Data = '0;
      endcase
   end

   always_comb begin
      HRDATA = '0;
      if (read_en) begin
         if (in_buf)
            HRDATA = tx_data[word_addr[PTR_W-1:0]];
         else if (word_addr == ADDR_BYTE_LEN)
            HRDATA = {26'd0, byte_len};
         else if (word_addr == ADDR_DEST)
            HRDATA = {28'd0, dest_addr};
         else if (word_addr == ADDR_STATUS)
            HRDATA = {29'd0, err, sent, busy};
      end
   end

endmodule

// File: tb/tb_ahb_tx.sv
// Directed bench for ahb_tx: register access, packet framing, ack stall, length
// rounding, error cases, busy protection and asynchronous reset mid-packet.
module tb_ahb_tx;

   logic        HCLK = 1'b0;
   logic        HRESET;
   logic [31:0] HADDR;
   logic [31:0] HWDATA;
   logic [2:0]  HSIZE;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic        HREADY;
   logic        HSEL;
   logic [31:0] HRDATA;
   logic        HREADYOUT;
   logic [3:0]  My_Addr;
   logic        M_Req;
   logic        M_Ack;
   logic [31:0] M_Data;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] pl [8];
   logic [31:0] rd;

   ahb_tx #(.MAX_WORDS(8)) dut (
      .HCLK      (HCLK),
      .HRESET    (HRESET),
      .HADDR     (HADDR),
      .HWDATA    (HWDATA),
      .HSIZE     (HSIZE),
      .HTRANS    (HTRANS),
      .HWRITE    (HWRITE),
      .HREADY    (HREADY),
      .HSEL      (HSEL),
      .HRDATA    (HRDATA),
      .HREADYOUT (HREADYOUT),
      .My_Addr   (My_Addr),
      .M_Req     (M_Req),
      .M_Ack     (M_Ack),
      .M_Data    (M_Data)
   );

   always #5 HCLK = ~HCLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Address phase on one cycle, data phase on the next; the write commits at the
   // edge following the task's return.
   task automatic ahb_write(input logic [4:0] a, input logic [31:0] d);
      @(posedge HCLK); #1;
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {25'd0, a, 2'b00};
      @(posedge HCLK); #1;
      HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
   endtask

   task automatic ahb_read(input logic [4:0] a, output logic [31:0] d);
      @(posedge HCLK); #1;
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {25'd0, a, 2'b00};
      @(posedge HCLK); #1;
      HSEL = 1'b0; HTRANS = 2'b00;
      d = HRDATA;
   endtask

   task automatic chk_status(input string tag, input logic [2:0] exp);
      logic [31:0] s;
      ahb_read(5'd16, s);
      chk(tag, s, {29'd0, exp});
   endtask

   // Send with M_Ack already high: header one cycle after the Send data phase, then words.
   task automatic send_pkt(input string tag, input int nw, input logic [31:0] hdr);
      ahb_write(5'd10, 32'd1);
      @(posedge HCLK); #1;
      chk({tag, "_req"}, {31'd0, M_Req}, 32'd1);
      chk({tag, "_hdr"}, M_Data, hdr);
      for (int i = 0; i < nw; i++) begin
         @(posedge HCLK); #1;
         chk($sformatf("%s_w%0d", tag, i), M_Data, pl[i]);
         chk($sformatf("%s_w%0d_req", tag, i), {31'd0, M_Req}, 32'd0);
      end
      @(posedge HCLK); #1;
      chk({tag, "_idle"}, M_Data, 32'd0);
   endtask

   task automatic no_req(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge HCLK); #1;
         chk(tag, {31'd0, M_Req}, 32'd0);
      end
   endtask

   initial begin
      HRESET = 1'b1; HADDR = '0; HWDATA = '0; HSIZE = 3'b010; HTRANS = 2'b00;
      HWRITE = 1'b0; HREADY = 1'b1; HSEL = 1'b0; My_Addr = 4'h5; M_Ack = 1'b1;
      for (int i = 0; i < 8; i++) pl[i] = 32'hA000_0000 + i;
      repeat (3) @(posedge HCLK);
      #1 HRESET = 1'b0;

      chk("rst_mreq", {31'd0, M_Req}, 32'd0);
      chk("rst_mdata", M_Data, 32'd0);
      chk("hreadyout", {31'd0, HREADYOUT}, 32'd1);
      chk_status("rst_status", 3'b000);

      // length 0 and 33 rejected, Sent still clear
      ahb_write(5'd8, 32'd0);
      ahb_write(5'd10, 32'd1);
      no_req("err0_noreq", 3);
      chk_status("err0_status", 3'b100);
      ahb_write(5'd8, 32'd33);
      ahb_write(5'd10, 32'd1);
      no_req("err33_noreq", 3);
      chk_status("err33_status", 3'b100);

      // basic 12-byte packet from node 5 to node 9
      for (int i = 0; i < 3; i++) ahb_write(5'(i), pl[i]);
      ahb_write(5'd8, 32'd12);
      ahb_write(5'd9, 32'h9);
      ahb_read(5'd8, rd);
      chk("rd_bytelen", rd, 32'd12);
      ahb_read(5'd2, rd);
      chk("rd_tx2", rd, pl[2]);
      send_pkt("basic", 3, 32'h0905_0C00);
      chk_status("basic_status", 3'b010);

      // ack withheld for 5 cycles
      M_Ack = 1'b0;
      ahb_write(5'd8, 32'd4);
      ahb_write(5'd10, 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(posedge HCLK); #1;
         chk("stall_req", {31'd0, M_Req}, 32'd1);
         chk("stall_hdr", M_Data, 32'h0905_0400);
      end
      M_Ack = 1'b1;
      @(posedge HCLK); #1;
      chk("stall_w0", M_Data, pl[0]);
      chk("stall_w0_req", {31'd0, M_Req}, 32'd0);
      @(posedge HCLK); #1;
      chk("stall_idle", M_Data, 32'd0);
      chk_status("stall_status", 3'b010);

      // 5 bytes round up to 2 words
      ahb_write(5'd8, 32'd5);
      send_pkt("round", 2, 32'h0905_0800);

      // full 32-byte packet
      for (int i = 0; i < 8; i++) begin
         pl[i] = 32'h1234_5600 ^ (32'h0101_0101 * (i + 1));
         ahb_write(5'(i), pl[i]);
      end
      ahb_write(5'd8, 32'd32);
      send_pkt("full", 8, 32'h0905_2000);
      chk_status("full_status", 3'b010);

      // error with Sent already set leaves Sent alone
      ahb_write(5'd8, 32'd33);
      ahb_write(5'd10, 32'd1);
      no_req("err_sent_noreq", 2);
      chk_status("err_sent_status", 3'b110);
      ahb_write(5'd8, 32'd32);

      // writes and a second Send during SEND are ignored
      ahb_write(5'd10, 32'd1);
      fork
         begin
            @(posedge HCLK); #1;
            chk("busy_hdr", M_Data, 32'h0905_2000);
            for (int i = 0; i < 8; i++) begin
               @(posedge HCLK); #1;
               chk($sformatf("busy_w%0d", i), M_Data, pl[i]);
            end
            @(posedge HCLK); #1;
            chk("busy_idle", M_Data, 32'd0);
         end
         begin
            ahb_write(5'd1, 32'hFFFF_FFFF);
            ahb_write(5'd10, 32'd1);
         end
      join
      no_req("busy_no2nd", 5);
      chk_status("busy_status", 3'b010);
      ahb_read(5'd1, rd);
      chk("busy_tx1", rd, pl[1]);

      // asynchronous reset during SEND
      ahb_write(5'd10, 32'd1);
      repeat (3) @(posedge HCLK);
      #1;
      chk("pre_rst_send", M_Data, pl[1]);
      HRESET = 1'b1;
      #1;
      chk("mid_rst_mreq", {31'd0, M_Req}, 32'd0);
      chk("mid_rst_mdata", M_Data, 32'd0);
      chk("mid_rst_hrdata", HRDATA, 32'd0);
      @(posedge HCLK); #1;
      HRESET = 1'b0;
      for (int a = 0; a < 10; a++) begin
         ahb_read(5'(a), rd);
         chk($sformatf("post_rst_reg%0d", a), rd, 32'd0);
      end
      chk_status("post_rst_status", 3'b000);
      no_req("post_rst_noreq", 2);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
